// File: rtl/prng_rnd_feeder.sv
// prng_rnd_feeder
//   Randomness producer for the masked HPC2 gadget bank. A seedable 64-bit
//   Fibonacci LFSR (x^64+x^63+x^61+x^60+1) is unrolled W steps per cycle and
//   streamed out over a valid/ready handshake, one fresh word per transfer.
//   Each (re)seed is followed by a WARMUP-cycle discard phase.
//
// Optional feature macro: FEEDER_RESEED_REQ_EN
//   defined   -> transfer counter and advisory reseed_req after RESEED_LIMIT transfers
//   undefined -> no counter, reseed_req tied to 0
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   in_seed[63:0]    : seed value (64'h0 is replaced by 64'h1)
//   in_seed_valid    : seed offered
//   in_seed_ready    : seed can be accepted (WAIT_SEED or RUN)
//   out_rnd[W-1:0]   : random word, bit k is the k-th generated bit of the step
//   out_valid        : out_rnd fresh and unconsumed
//   out_ready        : consumer takes out_rnd this cycle
//   reseed_req       : advisory reseed request
module prng_rnd_feeder #(
    parameter int unsigned d            = 2,
    parameter int unsigned NGADGETS     = 1,
    parameter int unsigned WARMUP       = 16,
    parameter int unsigned RESEED_LIMIT = 1024,
    localparam int unsigned W           = NGADGETS * d * (d - 1) / 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [63:0]   in_seed,
    input  logic          in_seed_valid,
    output logic          in_seed_ready,
    output logic [W-1:0]  out_rnd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          reseed_req
);

    localparam int unsigned CNT_W = 8;

    // Elaboration-time parameter range checks
    if (W < 1 || W > 64) begin : g_bad_w
        $error("prng_rnd_feeder: W must be in 1..64");
    end
    if (WARMUP < 1 || WARMUP > 255) begin : g_bad_warmup
        $error("prng_rnd_feeder: WARMUP must be in 1..255");
    end
    if (RESEED_LIMIT < 1) begin : g_bad_limit
        $error("prng_rnd_feeder: RESEED_LIMIT must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_WAIT_SEED = 2'd0,
        ST_WARMUP    = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [63:0]       s, s_next;
    logic [W-1:0]      rnd_next;
    logic              valid_next;
    logic [CNT_W-1:0]  wcnt, wcnt_next;
    logic              seed_acc;
    logic [63:0]       seed_fix;
    logic [W+63:0]     adv_run, adv_seed;

    // W unrolled LFSR steps: returns {collected fb bits, new state}
    function automatic logic [W+63:0] lfsr_adv(input logic [63:0] st);
        logic [63:0]  x;
        logic [W-1:0] bits;
        logic         fb;
        x    = st;
        bits = '0;
        for (int k = 0; k < W; k++) begin
            fb      = x[63] ^ x[62] ^ x[60] ^ x[59];
            bits[k] = fb;
            x       = {x[62:0], fb};
        end
        return {bits, x};
    endfunction

    assign seed_fix = (in_seed == 64'h0) ? 64'h1 : in_seed;
    assign adv_run  = lfsr_adv(s);
    // The accept cycle performs the first advance so that the word loaded on
    // the last warm-up cycle lands on bits W*WARMUP .. W*WARMUP+W-1.
    assign adv_seed = lfsr_adv(seed_fix);

    // Next-state and datapath decode
    always_comb begin
        state_next = state;
        s_next     = s;
        rnd_next   = out_rnd;
        valid_next = out_valid;
        wcnt_next  = wcnt;
        seed_acc   = 1'b0;
        case (state)
            ST_WAIT_SEED: begin
                seed_acc = in_seed_valid;
            end
            ST_WARMUP: begin
                s_next    = adv_run[63:0];
                wcnt_next = CNT_W'(wcnt - CNT_W'(1));
                if (wcnt == CNT_W'(1)) begin
                    rnd_next   = adv_run[W+63:64];
                    valid_next = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // A concurrent out_ready completes the old word; a seed wins over the advance.
                seed_acc = in_seed_valid;
                if (!in_seed_valid && out_ready) begin
                    s_next   = adv_run[63:0];
                    rnd_next = adv_run[W+63:64];
                end
            end
            default: begin
                state_next = ST_WAIT_SEED;
            end
        endcase
        if (seed_acc) begin
            s_next     = adv_seed[63:0];
            wcnt_next  = CNT_W'(WARMUP);
            valid_next = 1'b0;
            state_next = ST_WARMUP;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_WAIT_SEED;
            s             <= '0;
            out_rnd       <= '0;
            out_valid     <= 1'b0;
            in_seed_ready <= 1'b1;
            wcnt          <= '0;
        end else begin
            state         <= state_next;
            s             <= s_next;
            out_rnd       <= rnd_next;
            out_valid     <= valid_next;
            in_seed_ready <= (state_next != ST_WARMUP);
            wcnt          <= wcnt_next;
        end
    end

`ifdef FEEDER_RESEED_REQ_EN
    localparam int unsigned RC_W = $clog2(RESEED_LIMIT + 1);

    logic            xfer;
    logic [RC_W-1:0] xfer_cnt, xfer_cnt_next;

    assign xfer = (state == ST_RUN) && out_ready;

    // Saturating transfer counter, cleared on every seed acceptance
    always_comb begin
        xfer_cnt_next = xfer_cnt;
        if (seed_acc) begin
            xfer_cnt_next = '0;
        end else if (xfer && (xfer_cnt != RC_W'(RESEED_LIMIT))) begin
            xfer_cnt_next = RC_W'(xfer_cnt + RC_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt   <= '0;
            reseed_req <= 1'b0;
        end else begin
            xfer_cnt   <= xfer_cnt_next;
            reseed_req <= (xfer_cnt_next == RC_W'(RESEED_LIMIT));
        end
    end
`else
    assign reseed_req = 1'b0;
`endif

endmodule

// File: tb/tb_prng_rnd_feeder.sv
// Self-checking bench for prng_rnd_feeder: table of seeded runs checked
// against a bit-level LFSR model through a scoreboard queue, plus sequences
// for ready toggling, reseed during RUN, reset during warm-up and reseed_req.
module tb_prng_rnd_feeder;

    localparam int unsigned D  = 2;
    localparam int unsigned NG = 1;
    localparam int unsigned WU = 16;
    localparam int unsigned RL = 4;
    localparam int unsigned W  = NG * D * (D - 1) / 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   in_seed;
    logic          in_seed_valid;
    logic          in_seed_ready;
    logic [W-1:0]  out_rnd;
    logic          out_valid;
    logic          out_ready;
    logic          reseed_req;

    always #5 clk = ~clk;

    prng_rnd_feeder #(
        .d            (D),
        .NGADGETS     (NG),
        .WARMUP       (WU),
        .RESEED_LIMIT (RL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_seed       (in_seed),
        .in_seed_valid (in_seed_valid),
        .in_seed_ready (in_seed_ready),
        .out_rnd       (out_rnd),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .reseed_req    (reseed_req)
    );

    typedef struct {
        logic [63:0] seed;
        logic [63:0] ref_seed;
        int          n;
    } vec_t;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Golden LFSR: word i holds bits W*i .. W*i+W-1; words below WU are discarded
    task automatic push_words(input logic [63:0] seed, input int n);
        logic [63:0]  st;
        logic [W-1:0] wd;
        logic         fb;
        st = (seed == 64'h0) ? 64'h1 : seed;
        for (int i = 0; i < int'(WU) + n; i++) begin
            for (int k = 0; k < int'(W); k++) begin
                fb    = st[63] ^ st[62] ^ st[60] ^ st[59];
                wd[k] = fb;
                st    = {st[62:0], fb};
            end
            if (i >= int'(WU)) exp_q.push_back(wd);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_seed_valid = 1'b0; out_ready = 1'b0; in_seed = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send_seed(input logic [63:0] sd);
        in_seed = sd; in_seed_valid = 1'b1;
        @(posedge clk); #1;
        in_seed_valid = 1'b0;
    endtask

    // Counts edges until out_valid; bounded so a dead DUT still reaches the summary
    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!out_valid && k < 64) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, 64'(k), 64'(WU));
    endtask

    task automatic stream(input string name, input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check({name, "_valid"}, 64'(out_valid), 64'h1);
            if (exp_q.size() == 0) check({name, "_underflow"}, 64'h1, 64'h0);
            else                   check({name, "_word"}, 64'(out_rnd), 64'(exp_q.pop_front()));
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        int   pat[7];
        tbl[0] = '{seed: 64'h1,                   ref_seed: 64'h1,                   n: 32};
        tbl[1] = '{seed: 64'h0,                   ref_seed: 64'h1,                   n: 32};
        tbl[2] = '{seed: 64'hDEADBEEF_00000001,   ref_seed: 64'hDEADBEEF_00000001,   n: 24};
        tbl[3] = '{seed: 64'h0123_4567_89AB_CDEF, ref_seed: 64'h0123_4567_89AB_CDEF, n: 24};
        pat    = '{1, 0, 0, 1, 1, 0, 1};

        rst = 1'b1; in_seed = '0; in_seed_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid",  64'(out_valid),     64'h0);
        check("rst_out_rnd",    64'(out_rnd),       64'h0);
        check("rst_seed_ready", 64'(in_seed_ready), 64'h1);
        check("rst_reseed_req", 64'(reseed_req),    64'h0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_out_valid", 64'(out_valid), 64'h0);

        // Table of seeded runs
        for (int v = 0; v < 4; v++) begin
            do_reset();
            exp_q.delete();
            check("tbl_seed_ready", 64'(in_seed_ready), 64'h1);
            push_words(tbl[v].ref_seed, tbl[v].n);
            send_seed(tbl[v].seed);
            check("tbl_warm_seed_ready", 64'(in_seed_ready), 64'h0);
            wait_valid("tbl_latency");
            stream("tbl", tbl[v].n);
            check("tbl_sb_empty", 64'(exp_q.size()), 64'h0);
        end
`ifndef FEEDER_RESEED_REQ_EN
        check("reseed_req_tied", 64'(reseed_req), 64'h0);
`endif

        // out_ready toggling: word holds without handshake, advances exactly once per handshake
        do_reset();
        exp_q.delete();
        push_words(64'h0123_4567_89AB_CDEF, 10);
        send_seed(64'h0123_4567_89AB_CDEF);
        wait_valid("tog_latency");
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[i][0];
            check("tog_valid", 64'(out_valid), 64'h1);
            check("tog_word", 64'(out_rnd), 64'(exp_q[0]));
            @(posedge clk); #1;
            if (pat[i] != 0) void'(exp_q.pop_front());
        end
        out_ready = 1'b0;
        check("tog_hold_word", 64'(out_rnd), 64'(exp_q[0]));

        // Reseed in RUN with concurrent out_ready: old word completes, new seed starts clean
        check("rs_seed_ready_run", 64'(in_seed_ready), 64'h1);
        in_seed = 64'hDEADBEEF_00000001; in_seed_valid = 1'b1; out_ready = 1'b1;
        check("rs_old_word", 64'(out_rnd), 64'(exp_q.pop_front()));
        @(posedge clk); #1;
        in_seed_valid = 1'b0; out_ready = 1'b0;
        check("rs_valid_drop", 64'(out_valid), 64'h0);
        check("rs_seed_ready_warm", 64'(in_seed_ready), 64'h0);
        exp_q.delete();
        push_words(64'hDEADBEEF_00000001, 12);
        wait_valid("rs_latency");
        stream("rs", 12);

        // Reset pulse during warm-up
        do_reset();
        send_seed(64'h0123_4567_89AB_CDEF);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("wrst_out_valid",  64'(out_valid),     64'h0);
        check("wrst_out_rnd",    64'(out_rnd),       64'h0);
        check("wrst_seed_ready", 64'(in_seed_ready), 64'h1);
        check("wrst_reseed_req", 64'(reseed_req),    64'h0);
        repeat (20) @(posedge clk);
        #1;
        check("wrst_no_stale_valid", 64'(out_valid), 64'h0);
        exp_q.delete();
        push_words(64'hDEADBEEF_00000001, 4);
        send_seed(64'hDEADBEEF_00000001);
        wait_valid("wrst_latency");
        stream("wrst", 4);

`ifdef FEEDER_RESEED_REQ_EN
        // reseed_req after RL transfers, streaming continues, seed accept clears it
        do_reset();
        exp_q.delete();
        push_words(64'h0123_4567_89AB_CDEF, 8);
        send_seed(64'h0123_4567_89AB_CDEF);
        wait_valid("rr_latency");
        check("rr_initial", 64'(reseed_req), 64'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("rr_word", 64'(out_rnd), 64'(exp_q.pop_front()));
            @(posedge clk); #1;
            check("rr_req", 64'(reseed_req), (i + 1 >= int'(RL)) ? 64'h1 : 64'h0);
            check("rr_valid", 64'(out_valid), 64'h1);
        end
        out_ready = 1'b0;
        send_seed(64'h1);
        check("rr_clear", 64'(reseed_req), 64'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prng_rnd_feeder.md
# prng_rnd_feeder

Randomness source for the masked HPC2 gadgets: it produces `W = NGADGETS*d*(d-1)/2` fresh random bits per transfer over a valid/ready stream. It sits between the seed interface of the top level and the `rnd` inputs of the MSKand_hpc2 gadget bank. It is the producer end of the gadgets' randomness interface. Internally it holds a seedable 64-bit LFSR, unrolled `W` steps per cycle, with a warm-up phase after every (re)seed.

## Interface
- `d`, 2, number of shares; the per-gadget randomness is `d*(d-1)/2` bits.
- `NGADGETS`, 1, number of gadgets fed in parallel; `W = NGADGETS*d*(d-1)/2`, with 1 ≤ W ≤ 64.
- `WARMUP`, 16, number of discarded LFSR cycles after a seed is accepted; 1..255.
- `RESEED_LIMIT`, 1024, transfers before a reseed is requested; used only with `FEEDER_RESEED_REQ_EN`.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_seed` in 64: seed value.
- `in_seed_valid` in 1: seed offered.
- `in_seed_ready` out 1: seed can be accepted.
- `out_rnd` out W: random word; `out_rnd[k]` is the k-th bit generated in that step.
- `out_valid` out 1: `out_rnd` is fresh and unconsumed.
- `out_ready` in 1: consumer takes `out_rnd` this cycle.
- `reseed_req` out 1: reseed requested; constant 0 when the feature is compiled out.

## Operation
- **LFSR.**
  - State `s[63:0]`, polynomial x^64+x^63+x^61+x^60+1.
  - One step is: `fb = s[63]^s[62]^s[60]^s[59]`, then `s <= {s[62:0], fb}`.
  - One "advance" is W steps in a single cycle; the W `fb` bits are collected in order.
- **FSM states:** `WAIT_SEED`, `WARMUP`, `RUN`.
  - `WAIT_SEED`: `in_seed_ready=1`, `out_valid=0`. On `in_seed_valid`, load `s` from the seed and go to `WARMUP`. Counter := `WARMUP`.
  - `WARMUP`: `in_seed_ready=0`, `out_valid=0`. Advance every cycle and decrement the counter.
    - When the counter reaches 1, that cycle's advance loads `out_rnd`, and the FSM goes to `RUN`.
  - `RUN`: `in_seed_ready=1`, `out_valid=1`.
    - On `out_valid & out_ready`, advance and load `out_rnd` with the new word. `out_valid` stays 1, so back-to-back transfers run one per cycle.
    - With no handshake, `s` and `out_rnd` hold.
- **Zero seed.** A seed of 64'h0 is replaced by 64'h1; the all-zero state is never entered.
- **Reseed in `RUN`.**
  - `in_seed_valid` takes priority: load the seed, go to `WARMUP`, and `out_valid` is 0 from the next cycle.
  - If `out_ready` is also high in that cycle, that transfer completes: the consumer keeps the old word, and no advance is applied to the new seed.
- **Output registers.** `out_rnd` and `out_valid` are registers with no combinational path from `out_ready` or `in_seed_valid`. `in_seed_ready` is decoded from state only.
- **Single use.** A word is never presented valid twice. The consumer's gadget registers `rnd` itself, so this block provides one new word per handshake only.

## Timing
- **Reset values.** With `rst` high at an edge: state `WAIT_SEED`, `s=0`, `out_rnd=0`, `out_valid=0`, `in_seed_ready=1` after that edge, `reseed_req=0`, counters 0.
- **`rst` mid-operation.** Any state goes to reset values at the next edge. Any in-flight seed or word is discarded.
- **Seed latency.** A seed accepted at edge t gives the first `out_valid=1` after edge t+WARMUP. That first word is bits W*WARMUP .. W*WARMUP+W-1 of the sequence generated from the seed.
- **Output latency.** One handshake at edge t gives the next word visible after edge t. Throughput is W bits per cycle.

## Configuration
- **`FEEDER_RESEED_REQ_EN` defined:**
  - A transfer counter clears on every seed acceptance and increments on each `out_valid & out_ready`, saturating at `RESEED_LIMIT`.
  - `reseed_req` is a register that is 1 while the counter equals `RESEED_LIMIT`, and falls the cycle after a seed is accepted.
  - Output generation never stalls on `reseed_req`; it is advisory only.
- **Not defined:** no counter is built and `reseed_req` is tied to 0.

## Test plan
- Reset, then seed 64'h1 at cycle 0 with d=2, WARMUP=16 -> `out_valid` rises after edge 16; the first 32 words match the golden LFSR model bit-for-bit from bit 16 onward.
- Seed 64'h0 -> output sequence identical to the seed 64'h1 run.
- `out_ready` toggling 1,0,0,1 in `RUN` -> `out_rnd` changes only after the handshake edges and holds otherwise; no word is repeated or skipped.
- Reseed with 64'hDEADBEEF_00000001 while `out_ready=1` in `RUN` -> the old word is counted as transferred, `out_valid=0` for 16 cycles, then the new sequence matches the model.
- `rst` pulsed during `WARMUP` -> all outputs at reset values on the next edge; `in_seed_ready=1`.
- With `FEEDER_RESEED_REQ_EN` and `RESEED_LIMIT=4` -> `reseed_req=1` after the 4th transfer, and streaming continues. A seed accept clears it one cycle later.
